sequential_divider: RTL and testbench

Multi-cycle unsigned restoring divider: the inverse arithmetic of the 8-bit adder. It takes a 9-bit dividend, the full width of an 8-bit + 8-bit sum, and an 8-bit divisor. It produces one quotient bit per clock, using a start/busy/done handshake so that a switch panel or upstream logic can launch a division and sample the result. Quotient and remainder are registered and held stable between operations so they can drive indicator attachments directly.

---
 rtl/sequential_divider.sv | 149 ++++++++++++++
 tb/tb_sequential_divider.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// sequential_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A start/busy/done handshake launches a division. The quotient, remainder
// and div_by_zero outputs are registered and hold their last completed value
// between operations, so they can drive indicators directly.

module sequential_divider #(
  parameter int DIVIDEND_WIDTH = 9,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);

  // The counter must be able to hold DIVIDEND_WIDTH itself.
  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working registers. acc_q starts as the dividend; each cycle its MSB is
  // shifted into the partial remainder and the new quotient bit enters at
  // the LSB, so after DIVIDEND_WIDTH steps it holds the full quotient.
  logic [DIVIDEND_WIDTH-1:0] acc_q;
  logic [DIVISOR_WIDTH-1:0]  dvs_q;
  logic [DIVISOR_WIDTH:0]    prem_q;
  logic [CW-1:0]             cnt_q;

  // Control strobes decoded by the FSM.
  logic load;       // accepted start with a non-zero divisor
  logic zero_div;   // accepted start with a zero divisor
  logic finish;     // last RUN iteration, results are committed this edge

  // One restoring step, computed from the current working registers.
  logic [DIVISOR_WIDTH:0]    shifted;
  logic [DIVISOR_WIDTH+1:0]  trial;
  logic                      qbit;
  logic [DIVISOR_WIDTH:0]    prem_step;
  logic [DIVIDEND_WIDTH-1:0] acc_step;
  logic                      last_iter;

  // Shift in the next dividend bit and trial-subtract the divisor. One extra
  // bit on the subtraction gives the borrow, which decides keep or restore.
  // prem_q is always below the divisor, so its top bit is zero and dropping
  // it in the shift loses nothing.
  assign shifted   = {prem_q[DIVISOR_WIDTH-1:0], acc_q[DIVIDEND_WIDTH-1]};
  assign trial     = {1'b0, shifted} - {2'b00, dvs_q};
  assign qbit      = ~trial[DIVISOR_WIDTH+1];
  assign prem_step = qbit ? trial[DIVISOR_WIDTH:0] : shifted;
  assign acc_step  = {acc_q[DIVIDEND_WIDTH-2:0], qbit};
  assign last_iter = (cnt_q == CW'(1));

  // Handshake outputs are plain decodes of the registered state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and control strobes.
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    zero_div  = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_nxt = DONE;
            zero_div  = 1'b1;
          end else begin
            state_nxt = RUN;
            load      = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        // start and operand changes are ignored while running.
        if (last_iter) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working datapath: capture operands on launch, one step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= dividend;
      dvs_q  <= divisor;
      prem_q <= '0;
      cnt_q  <= CW'(DIVIDEND_WIDTH);
    end else if (state == RUN) begin
      acc_q  <= acc_step;
      prem_q <= prem_step;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  // Result registers: change only when entering DONE (or on reset). The last
  // step's values are taken straight from the step logic so the final
  // quotient bit is included without an extra cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (finish) begin
      quotient    <= acc_step;
      remainder   <= prem_step[DIVISOR_WIDTH-1:0];
      div_by_zero <= 1'b0;
    end else if (zero_div) begin
      quotient    <= '1;
      remainder   <= '0;
      div_by_zero <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider
// Directed and randomized checks of sequential_divider against plain integer
// division. Inputs are driven and outputs sampled on the falling clock edge.

module tb_sequential_divider;

  localparam int DW = 9;
  localparam int VW = 8;
  localparam int NRUN = DW;          // cycles from accepted start to done

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int total = 0;
  int bad   = 0;

  sequential_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the zero-divisor convention.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << DW) - 1 : a / b;
  endfunction
  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? 0 : a % b;
  endfunction

  // Launch one division and check handshake timing plus results.
  // poke > 0 pulses start with other operands on that RUN cycle.
  task automatic do_div(input int a, input int b, input int poke);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; dividend = DW'(a); divisor = VW'(b);
    @(negedge clk);
    // Scramble operands: changes after acceptance must not matter.
    start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
    if (b == 0) begin
      check("z_done", done, 1);
      check("z_busy", busy, 0);
    end else begin
      cycles = 0; busy_cnt = 0;
      while (!done && cycles < 3 * NRUN) begin
        busy_cnt += int'(busy);
        cycles++;
        @(negedge clk);
        if (poke != 0 && cycles == poke) begin
          start = 1'b1; dividend = 9'd50; divisor = 8'd2;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      check("done_seen", done, 1);
      check("latency", cycles, NRUN);
      check("busy_cycles", busy_cnt, NRUN);
      check("busy_at_done", busy, 0);
    end
    check("quotient", quotient, ref_q(a, b));
    check("remainder", remainder, ref_r(a, b));
    check("dbz", div_by_zero, (b == 0) ? 1 : 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("q_hold", quotient, ref_q(a, b));
    check("r_hold", remainder, ref_r(a, b));
  endtask

  initial begin
    int d, v, seen, last_t, n_res, waits;
    // Reset state.
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_div(510, 7, 0);
    do_div(510, 1, 0);
    do_div(0, 5, 0);
    do_div(200, 255, 0);
    do_div(100, 0, 0);
    do_div(100, 3, 0);
    do_div(300, 9, 4);      // start pulse during RUN is ignored
    repeat (3) @(negedge clk);
    check("idle_hold_q", quotient, 33);
    check("idle_hold_r", remainder, 3);
    check("idle_busy", busy, 0);

    // Reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; dividend = 9'd400; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen += int'(done) + int'(busy);
    end
    check("no_done_after_rst", seen, 0);
    do_div(400, 3, 0);

    // Start held high: a result every NRUN+1 cycles.
    @(negedge clk);
    start = 1'b1; dividend = 9'd510; divisor = 8'd7;
    last_t = -1; n_res = 0; waits = 0;
    while (n_res < 4 && waits < 100) begin
      @(negedge clk);
      waits++;
      if (done) begin
        if (last_t >= 0) check("b2b_period", waits - last_t, NRUN + 1);
        check("b2b_q", quotient, 72);
        check("b2b_r", remainder, 6);
        last_t = waits;
        n_res++;
      end
    end
    check("b2b_count", n_res, 4);
    start = 1'b0;
    waits = 0;
    while ((busy || done) && waits < 30) begin
      @(negedge clk);
      waits++;
    end
    check("b2b_drain", busy, 0);

    // Randomized operands, with zero divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, (1 << DW) - 1));
      v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << VW) - 1));
      do_div(d, v, 0);
    end
    // Boundary: maximal dividend against maximal divisor.
    do_div(511, 255, 0);
    do_div(254, 255, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
